// File: rtl/time_setter_pkg.sv
// Shared types and helpers for the time_setter block: FSM states, the
// minutes/seconds field type and the wrap-around step functions.
package time_setter_pkg;

  localparam int FIELD_W = 6;

  typedef logic [FIELD_W-1:0] field_t;

  localparam field_t MAX_MINSEC = 6'd59;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_MIN = 2'd1,
    EDIT_SEC = 2'd2
  } state_t;

  function automatic field_t step_up(input field_t v);
    return (v == MAX_MINSEC) ? '0 : v + 1'b1;
  endfunction

  function automatic field_t step_down(input field_t v);
    return (v == '0) ? MAX_MINSEC : v - 1'b1;
  endfunction

endpackage

// File: rtl/time_setter_if.sv
// Button, running-time and edited-time signals of time_setter, plus the FSM
// state for observation. master = stimulus/upstream side, slave = time_setter.
interface time_setter_if;
  import time_setter_pkg::*;

  logic   btn_mode;
  logic   btn_field;
  logic   btn_up;
  logic   btn_down;
  field_t Minutos;
  field_t Segundos;
  logic   setTime;
  field_t MinutosPulsa;
  field_t SegundosPulsa;
  logic   field_sel;
  logic   load_time;
  state_t state_dbg;

  modport master (
    output btn_mode, btn_field, btn_up, btn_down, Minutos, Segundos,
    input  setTime, MinutosPulsa, SegundosPulsa, field_sel, load_time, state_dbg
  );

  modport slave (
    input  btn_mode, btn_field, btn_up, btn_down, Minutos, Segundos,
    output setTime, MinutosPulsa, SegundosPulsa, field_sel, load_time, state_dbg
  );

endinterface

// File: rtl/btn_debounce.sv
// One push-button path: 2-FF synchronizer, stability counter that accepts a
// new level after DEBOUNCE_CYCLES identical samples, and a rising-edge strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample matching the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/time_setter.sv
// User time-entry stage: debounces four buttons and runs the IDLE/EDIT_MIN/
// EDIT_SEC editor. Auto-repeat of up/down is built with TIME_SETTER_AUTO_REPEAT_EN.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic          clk,
  input logic          rst_n,
  time_setter_if.slave bus
);

  logic mode_lvl, field_lvl, up_lvl, down_lvl;
  logic mode_press, field_press, up_press, down_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_mode), .level(mode_lvl), .press(mode_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_field (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_field), .level(field_lvl), .press(field_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_up), .level(up_lvl), .press(up_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_down), .level(down_lvl), .press(down_press)
  );

  state_t state;
  logic   set_time_q;
  logic   load_q;
  logic   field_q;
  field_t min_q;
  field_t sec_q;
  logic   rep_up;
  logic   rep_down;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 2);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_active;
  logic          rpt_fire;

  // Counting starts the cycle the debounced level rises, which is two cycles
  // before the press step lands; the +1 offset keeps REPEAT_DELAY measured
  // from the press step itself.
  assign rpt_active = (state != IDLE) && (up_lvl ^ down_lvl);
  assign rpt_fire   = rpt_active && (rpt_cnt == RW'(REPEAT_DELAY + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
    end else if (!rpt_active || mode_press || field_press) begin
      rpt_cnt <= '0;
    end else if (rpt_fire) begin
      rpt_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 2);
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  assign rep_up   = rpt_fire & up_lvl;
  assign rep_down = rpt_fire & down_lvl;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
`endif

  logic unused_levels;
  assign unused_levels = ^{mode_lvl, field_lvl, up_lvl, down_lvl};

  logic inc_req;
  logic dec_req;
  assign inc_req = up_press | rep_up;
  assign dec_req = down_press | rep_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      set_time_q <= 1'b0;
      load_q     <= 1'b0;
      field_q    <= 1'b0;
      min_q      <= '0;
      sec_q      <= '0;
    end else begin
      load_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_press) begin
            min_q      <= bus.Minutos;
            sec_q      <= bus.Segundos;
            state      <= EDIT_MIN;
            set_time_q <= 1'b1;
            field_q    <= 1'b0;
          end
        end
        EDIT_MIN, EDIT_SEC: begin
          // mode beats field beats a step; opposite steps cancel.
          if (mode_press) begin
            state      <= IDLE;
            set_time_q <= 1'b0;
            load_q     <= 1'b1;
            field_q    <= 1'b0;
          end else if (field_press) begin
            state   <= (state == EDIT_MIN) ? EDIT_SEC : EDIT_MIN;
            field_q <= (state == EDIT_MIN);
          end else if (inc_req ^ dec_req) begin
            if (state == EDIT_MIN) begin
              min_q <= inc_req ? step_up(min_q) : step_down(min_q);
            end else begin
              sec_q <= inc_req ? step_up(sec_q) : step_down(sec_q);
            end
          end
        end
        default: begin
          state      <= IDLE;
          set_time_q <= 1'b0;
          field_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.setTime       = set_time_q;
  assign bus.load_time     = load_q;
  assign bus.field_sel     = field_q;
  assign bus.MinutosPulsa  = min_q;
  assign bus.SegundosPulsa = sec_q;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter with short debounce/repeat settings; every
// load strobe is matched against an expected {minutes, seconds} queue.
module tb_time_setter;
  import time_setter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  time_setter_if bus ();

  time_setter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_loads  = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.load_time) begin
      n_loads++;
      if (exp_q.size() == 0) begin
        check("load_unexpected", 32'(bus.load_time), 32'd0);
      end else begin
        check("load_value", 32'({bus.MinutosPulsa, bus.SegundosPulsa}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask = {mode, field, up, down}; all selected buttons rise and fall together.
  task automatic pulse(input logic [3:0] mask);
    bus.btn_mode  = mask[3];
    bus.btn_field = mask[2];
    bus.btn_up    = mask[1];
    bus.btn_down  = mask[0];
    tick(12);
    bus.btn_mode  = 1'b0;
    bus.btn_field = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    tick(12);
  endtask

  task automatic check_edit(input string tag, input logic [5:0] m, input logic [5:0] s);
    check({tag, "_min"}, 32'(bus.MinutosPulsa), 32'(m));
    check({tag, "_sec"}, 32'(bus.SegundosPulsa), 32'(s));
  endtask

  localparam logic [3:0] B_MODE  = 4'b1000;
  localparam logic [3:0] B_FIELD = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b0010;
  localparam logic [3:0] B_DOWN  = 4'b0001;

  // ---------------- stimulus ----------------
  initial begin
    int  l0;
    logic got;

    bus.btn_mode  = 1'b0;
    bus.btn_field = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.Minutos   = 6'd0;
    bus.Segundos  = 6'd0;
    tick(3);
    check("rst_settime", 32'(bus.setTime), 32'd0);
    check("rst_load", 32'(bus.load_time), 32'd0);
    check("rst_field", 32'(bus.field_sel), 32'd0);
    check_edit("rst", 6'd0, 6'd0);
    rst_n = 1'b1;
    tick(2);

    // Idle: up/down/field are ignored.
    bus.Minutos  = 6'd7;
    bus.Segundos = 6'd8;
    pulse(B_UP);
    pulse(B_DOWN);
    pulse(B_FIELD);
    check("idle_settime", 32'(bus.setTime), 32'd0);
    check("idle_field", 32'(bus.field_sel), 32'd0);
    check_edit("idle", 6'd0, 6'd0);

    // Enter edit: capture running time.
    bus.Minutos  = 6'd12;
    bus.Segundos = 6'd34;
    pulse(B_MODE);
    check("enter_settime", 32'(bus.setTime), 32'd1);
    check("enter_field", 32'(bus.field_sel), 32'd0);
    check("enter_state", 32'(bus.state_dbg), 32'(EDIT_MIN));
    check_edit("enter", 6'd12, 6'd34);

    exp_q.push_back({6'd12, 6'd34});
    l0 = n_loads;
    pulse(B_MODE);
    check("exit1_loads", 32'(n_loads - l0), 32'd1);
    check("exit1_settime", 32'(bus.setTime), 32'd0);
    check_edit("exit1_hold", 6'd12, 6'd34);

    // Wrap boundaries: 59 + up -> 0, 0 - down -> 59.
    bus.Minutos  = 6'd59;
    bus.Segundos = 6'd0;
    pulse(B_MODE);
    check_edit("wrap_enter", 6'd59, 6'd0);
    pulse(B_UP);
    check_edit("wrap_up", 6'd0, 6'd0);
    pulse(B_FIELD);
    check("wrap_field", 32'(bus.field_sel), 32'd1);
    check("wrap_state", 32'(bus.state_dbg), 32'(EDIT_SEC));
    pulse(B_DOWN);
    check_edit("wrap_down", 6'd0, 6'd59);
    exp_q.push_back({6'd0, 6'd59});
    l0 = n_loads;
    pulse(B_MODE);
    check("exit2_loads", 32'(n_loads - l0), 32'd1);
    check("exit2_settime", 32'(bus.setTime), 32'd0);
    check("exit2_field", 32'(bus.field_sel), 32'd0);
    check_edit("exit2_hold", 6'd0, 6'd59);

    // Bounce shorter than the debounce window, then a clean hold.
    bus.Minutos  = 6'd5;
    bus.Segundos = 6'd10;
    pulse(B_MODE);
    check_edit("bounce_enter", 6'd5, 6'd10);
    for (int i = 0; i < 10; i++) begin
      bus.btn_up = (i % 2 == 0);
      tick(2);
    end
    check_edit("bounce_none", 6'd5, 6'd10);
    bus.btn_up = 1'b1;
    tick(12);
    bus.btn_up = 1'b0;
    tick(12);
    check_edit("bounce_one", 6'd6, 6'd10);

    // Up and down together cancel; mode beats up.
    pulse(B_UP | B_DOWN);
    check_edit("updown", 6'd6, 6'd10);
    exp_q.push_back({6'd6, 6'd10});
    l0 = n_loads;
    pulse(B_MODE | B_UP);
    check("modeup_loads", 32'(n_loads - l0), 32'd1);
    check("modeup_settime", 32'(bus.setTime), 32'd0);
    check_edit("modeup", 6'd6, 6'd10);

    // Held up button: first step at press, repeats at +20, +25, +30, +35.
    bus.Minutos  = 6'd10;
    bus.Segundos = 6'd0;
    pulse(B_MODE);
    check_edit("hold_enter", 6'd10, 6'd0);
    bus.btn_up = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.MinutosPulsa != 6'd10) begin
        got = 1'b1;
        break;
      end
    end
    check("hold_first_seen", 32'(got), 32'd1);
    check("hold_first_val", 32'(bus.MinutosPulsa), 32'd11);
    // Debounced release lands 6 cycles after the raw release: step +37.
    repeat (31) @(posedge clk);
    #1;
    bus.btn_up = 1'b0;
    tick(20);
`ifdef TIME_SETTER_AUTO_REPEAT_EN
    check("hold_total", 32'(bus.MinutosPulsa), 32'd15);
`else
    check("hold_total", 32'(bus.MinutosPulsa), 32'd11);
`endif
    check("hold_sec", 32'(bus.SegundosPulsa), 32'd0);

    // Reset in the middle of a hold while editing.
    bus.btn_up = 1'b1;
    tick(20);
    check("prereset_settime", 32'(bus.setTime), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_settime", 32'(bus.setTime), 32'd0);
    check("midrst_load", 32'(bus.load_time), 32'd0);
    check("midrst_field", 32'(bus.field_sel), 32'd0);
    check("midrst_state", 32'(bus.state_dbg), 32'(IDLE));
    check_edit("midrst", 6'd0, 6'd0);
    bus.btn_up = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("postrst_settime", 32'(bus.setTime), 32'd0);
    check_edit("postrst", 6'd0, 6'd0);

    check("loads_total", 32'(n_loads), 32'd3);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_setter.md
# time_setter

User time-entry stage directly upstream of the clock's minutes/seconds display selector. It debounces four push-buttons and runs a mode state machine that produces `setTime` and the edited `MinutosPulsa`/`SegundosPulsa` values. While editing is active, the selector shows these values in place of the running time. On exit, the block issues a one-cycle load strobe so the time counter takes the edited value.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz).
- `REPEAT_DELAY`, default 25000000: cycles `btn_up`/`btn_down` must be held before auto-repeat starts.
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat steps.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: raw button, active-high, asynchronous; enters or leaves edit mode.
- `btn_field` in 1: raw button; toggles the edited field.
- `btn_up` in 1: raw button; increments the edited field.
- `btn_down` in 1: raw button; decrements the edited field.
- `Minutos` in 6: current running minutes, 0..59.
- `Segundos` in 6: current running seconds, 0..59.
- `setTime` out 1: 1 while in edit mode.
- `MinutosPulsa` out 6: edited minutes.
- `SegundosPulsa` out 6: edited seconds.
- `field_sel` out 1: 0 = minutes edited, 1 = seconds edited.
- `load_time` out 1: one-cycle strobe; the counter loads `MinutosPulsa`/`SegundosPulsa`.

## Operation
- Each button path: 2-FF synchronizer, then debounce counter, then rising-edge detector producing a one-cycle `*_press` strobe.
- FSM states: `IDLE`, `EDIT_MIN`, `EDIT_SEC`.
- `IDLE` + `mode_press`:
  - Capture `Minutos`/`Segundos` into the edit registers.
  - Go to `EDIT_MIN`.
  - `setTime`=1.
- `EDIT_MIN`/`EDIT_SEC` + `field_press`: toggle between the two edit states.
- `EDIT_*` + `mode_press`:
  - Go to `IDLE`.
  - `setTime`=0.
  - `load_time`=1 for exactly one cycle.
  - Edit registers hold their value.
- `mode_press` has priority over `field_press`, `up_press` and `down_press` in the same cycle.
- Up step: value == 59 → 0, else +1. Down step: value == 0 → 59, else −1. Arithmetic is 6-bit and never leaves 0..59.
- `up_press` and `down_press` in the same cycle: no change.
- In `IDLE`, field/up/down presses are ignored.
- A step applies only to the register selected by the current state. A simultaneous `field_press` switches the field; the step is dropped.
- `field_sel` reflects the state (`EDIT_SEC` → 1). In `IDLE` it holds 0.
- Reset (any time, including mid-edit):
  - State `IDLE`; `setTime`, `load_time`, `field_sel` = 0.
  - `MinutosPulsa`/`SegundosPulsa` = 0.
  - All synchronizers, debounce counters and repeat counters clear.
  - Debounced levels = 0.

## Timing
- All outputs are registered.
- Raw edge to `*_press`: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 edge cycle.
- `*_press` to output change (`setTime`, edit value, `field_sel`, `load_time`): 1 cycle.
- `load_time` asserts in the same cycle that `setTime` falls.
- A bounce shorter than `DEBOUNCE_CYCLES` resets the stability counter and produces no press.
- A held button produces exactly one press; a release produces none.

## Configuration
- `TIME_SETTER_AUTO_REPEAT_EN` defined:
  - While debounced up (or down) stays high in an edit state, one extra step is issued after `REPEAT_DELAY` cycles, then one every `REPEAT_PERIOD` cycles until release.
  - The repeat counter clears on release, on state change, and when both up and down are held.
- Undefined: repeat counters are not built; one step per press only.

## Structure
- Shared package `time_setter_pkg`:
  - FSM state enum.
  - `MAX_MINSEC` = 59.
  - Field width 6.
- Sub-module `btn_debounce` (synchronizer + debounce + edge detect, parameter `DEBOUNCE_CYCLES`; outputs `level` and `press`), instantiated four times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.
- Reset then idle: `setTime`=0, `MinutosPulsa`=0, `SegundosPulsa`=0, `load_time` never asserts; up/down presses change nothing.
- `Minutos`=12, `Segundos`=34, press mode: `setTime`=1, `MinutosPulsa`=12, `SegundosPulsa`=34, `field_sel`=0.
- Edit minutes 59 + one up → 0. Press field, seconds 0 + one down → 59. Press mode: `load_time` is high for exactly 1 cycle, `setTime`=0, outputs hold 0/59.
- Up line toggles 0/1 every 2 cycles for 20 cycles, then stays high: exactly one increment.
- Up and down pressed in the same cycle: value unchanged. Mode and up in the same cycle while editing: exit with `load_time`, no increment.
- With the macro defined, hold up for 40 cycles after press acceptance: value +1 at press, +1 at 20 cycles, then +1 every 5 cycles (5 steps total). Without the macro: +1 only. `rst_n` low mid-hold: immediate reset values.
